// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one SDRAM controller among NUM_PORTS
// requesters. One transaction in flight at a time; the controller's level
// rd/we strobes are driven and its rd_rdy/we_rdy are watched falling
// (accepted) then rising (done), after which the winner gets a one-cycle ack.
module sdram_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int PW        = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    req,
   input  logic [NUM_PORTS-1:0]    req_we,
   input  logic [25*NUM_PORTS-1:0] req_addr,
   input  logic [32*NUM_PORTS-1:0] req_wdata,
   input  logic [4*NUM_PORTS-1:0]  req_be,
   output logic [NUM_PORTS-1:0]    ack,
   output logic [31:0]             rdata,
   output logic                    sd_rd,
   output logic [24:0]             sd_raddr,
   output logic                    sd_we,
   output logic [24:0]             sd_waddr,
   output logic [31:0]             sd_din,
   output logic [3:0]              sd_be,
   input  logic                    sd_rd_rdy,
   input  logic                    sd_we_rdy,
   input  logic [31:0]             sd_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state;
   logic [PW-1:0] last;
   logic [PW-1:0] grant;
   logic [PW-1:0] winner;
   logic [PW-1:0] cand;
   logic          found;
   logic          is_write;

   // Round-robin search: first requesting port after the last one served.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         cand = PW'((int'(last) + i) % NUM_PORTS);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Grant / issue / wait sequencer; every output is a register here.
   // A grant is held off during an ack cycle so a requester that has just
   // been served is not re-granted before it has had a chance to drop req.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         last     <= PW'(NUM_PORTS - 1);
         grant    <= '0;
         is_write <= 1'b0;
         ack      <= '0;
         rdata    <= '0;
         sd_rd    <= 1'b0;
         sd_we    <= 1'b0;
         sd_raddr <= '0;
         sd_waddr <= '0;
         sd_din   <= '0;
         sd_be    <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (found && sd_rd_rdy && sd_we_rdy && (ack == '0)) begin
                  grant    <= winner;
                  is_write <= req_we[winner];
                  sd_raddr <= req_addr[int'(winner)*25 +: 25];
                  sd_waddr <= req_addr[int'(winner)*25 +: 25];
                  sd_din   <= req_wdata[int'(winner)*32 +: 32];
                  sd_be    <= req_be[int'(winner)*4 +: 4];
                  sd_we    <= req_we[winner];
                  sd_rd    <= !req_we[winner];
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (is_write && !sd_we_rdy) begin
                  sd_we <= 1'b0;
                  state <= WAIT;
               end else if (!is_write && !sd_rd_rdy) begin
                  sd_rd <= 1'b0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if ((is_write && sd_we_rdy) || (!is_write && sd_rd_rdy)) begin
                  ack[grant] <= 1'b1;
                  if (!is_write) begin
                     rdata <= sd_dout;
                  end
                  last  <= grant;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed tests with a scoreboard. Stimulus pushes the
// expected ack (port, address, data) into a queue; a monitor pops and
// compares whenever the arbiter raises ack. A small SDRAM controller model
// accepts strobes at slot starts and completes 8 clocks later.
module tb_sdram_arbiter;

   localparam int NP = 3;

   typedef struct {
      int          port;
      bit          we;
      logic [24:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } exp_t;

   logic              clk;
   logic              reset;
   logic [NP-1:0]     req;
   logic [NP-1:0]     req_we;
   logic [25*NP-1:0]  req_addr;
   logic [32*NP-1:0]  req_wdata;
   logic [4*NP-1:0]   req_be;
   logic [NP-1:0]     ack;
   logic [31:0]       rdata;
   logic              sd_rd;
   logic [24:0]       sd_raddr;
   logic              sd_we;
   logic [24:0]       sd_waddr;
   logic [31:0]       sd_din;
   logic [3:0]        sd_be;
   logic              sd_rd_rdy;
   logic              sd_we_rdy;
   logic [31:0]       sd_dout;

   int   tests = 0;
   int   fails = 0;
   int   acks_seen = 0;
   int   accepts = 0;
   int   issued [NP];
   int   done_cnt [NP];
   exp_t sb [$];

   logic [31:0] mem [0:255];
   logic        ctl_busy;
   logic [3:0]  ctl_cnt;
   logic        ctl_wr;
   logic [24:0] ctl_addr;
   logic [2:0]  phase;
   logic        prev_rd;
   logic        prev_we;

   sdram_arbiter #(.NUM_PORTS(NP), .PW(2)) dut (
      .clk(clk), .reset(reset),
      .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .ack(ack), .rdata(rdata),
      .sd_rd(sd_rd), .sd_raddr(sd_raddr), .sd_we(sd_we), .sd_waddr(sd_waddr),
      .sd_din(sd_din), .sd_be(sd_be),
      .sd_rd_rdy(sd_rd_rdy), .sd_we_rdy(sd_we_rdy), .sd_dout(sd_dout)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A port requests while it has outstanding issued transactions.
   always_comb begin
      req = '0;
      for (int i = 0; i < NP; i++) begin
         req[i] = (issued[i] != done_cnt[i]);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input int port, input bit we, input logic [24:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be, input int n);
      req_we[port]             = we;
      req_addr[port*25 +: 25]  = addr;
      req_wdata[port*32 +: 32] = wdata;
      req_be[port*4 +: 4]      = be;
      issued[port]             = issued[port] + n;
   endtask

   task automatic push_exp(input int port, input bit we, input logic [24:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
      exp_t e;
      e.port = port;
      e.we   = we;
      e.addr = addr;
      e.data = data;
      e.be   = be;
      sb.push_back(e);
   endtask

   task automatic cancel_all();
      for (int i = 0; i < NP; i++) begin
         issued[i] = done_cnt[i];
      end
      sb.delete();
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      cancel_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int budget;
      budget = 400;
      while ((sb.size() != 0 || req != '0) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s: drain timeout, %0d acks still pending", name, sb.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // Controller model: accepts a strobe at a slot start, drops the matching
   // rdy, and after 8 clocks applies the write or returns read data.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[64] <= 32'hDEADBEEF;
      mem[1]  <= 32'hAABBCCDD;
      mem[2]  <= 32'h11111111;
      mem[3]  <= 32'h22222222;
      mem[4]  <= 32'h33333333;
      mem[5]  <= 32'h55555555;
      sd_rd_rdy <= 1'b1;
      sd_we_rdy <= 1'b1;
      sd_dout   <= 32'h0;
      ctl_busy  <= 1'b0;
      ctl_cnt   <= 4'd0;
      ctl_wr    <= 1'b0;
      ctl_addr  <= 25'd0;
      phase     <= 3'd0;
      forever begin
         @(posedge clk);
         phase <= phase + 3'd1;
         if (!ctl_busy) begin
            if (phase == 3'd0 && (sd_rd || sd_we)) begin
               ctl_busy <= 1'b1;
               ctl_cnt  <= 4'd8;
               ctl_wr   <= sd_we;
               ctl_addr <= sd_raddr;
               accepts  <= accepts + 1;
               if (sd_we) sd_we_rdy <= 1'b0;
               else       sd_rd_rdy <= 1'b0;
            end
         end else begin
            ctl_cnt <= ctl_cnt - 4'd1;
            if (ctl_cnt == 4'd1) begin
               ctl_busy <= 1'b0;
               if (ctl_wr) begin
                  for (int b = 0; b < 4; b++) begin
                     if (sd_be[b]) mem[sd_waddr[9:2]][b*8 +: 8] <= sd_din[b*8 +: 8];
                  end
                  sd_we_rdy <= 1'b1;
               end else begin
                  sd_dout   <= mem[ctl_addr[9:2]];
                  sd_rd_rdy <= 1'b1;
               end
            end
         end
      end
   end

   // Requesters: count completions so a port's req drops after its last ack.
   initial begin
      for (int i = 0; i < NP; i++) done_cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) begin
            if (ack[i] && done_cnt[i] != issued[i]) done_cnt[i] = done_cnt[i] + 1;
         end
      end
   end

   // Monitor: strobe exclusion, no new strobe while the controller is busy,
   // and scoreboard comparison on every ack.
   initial begin
      exp_t e;
      prev_rd = 1'b0;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         if (sd_rd || sd_we) checkOutput("strobe_exclusive", {63'd0, sd_rd & sd_we}, 64'd0);
         if ((sd_rd && !prev_rd) || (sd_we && !prev_we))
            checkOutput("strobe_while_busy", {63'd0, ctl_busy}, 64'd0);
         prev_rd = sd_rd;
         prev_we = sd_we;
         if (ack != '0) begin
            acks_seen++;
            checkOutput("ack_onehot", {63'd0, $onehot(ack)}, 64'd1);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_ack: got %b, expected none", ack);
            end else begin
               e = sb.pop_front();
               checkOutput("ack_port", 64'(ack), 64'(1 << e.port));
               if (e.we) begin
                  checkOutput("waddr", 64'(sd_waddr), 64'(e.addr));
                  checkOutput("wdata", 64'(sd_din), 64'(e.data));
                  checkOutput("wbe", 64'(sd_be), 64'(e.be));
               end else begin
                  checkOutput("raddr", 64'(sd_raddr), 64'(e.addr));
                  checkOutput("rdata", 64'(rdata), 64'(e.data));
               end
            end
         end
      end
   end

   // Global watchdog so the run always ends.
   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
      $fatal(1, "[TB] watchdog");
   end

   // Directed test sequence.
   initial begin
      int budget;
      reset     = 1'b1;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      for (int i = 0; i < NP; i++) issued[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ack", 64'(ack), 64'd0);
      checkOutput("reset_sd_rd", {63'd0, sd_rd}, 64'd0);
      checkOutput("reset_sd_we", {63'd0, sd_we}, 64'd0);
      checkOutput("reset_rdata", 64'(rdata), 64'd0);
      checkOutput("reset_raddr", 64'(sd_raddr), 64'd0);
      checkOutput("reset_waddr", 64'(sd_waddr), 64'd0);
      checkOutput("reset_din", 64'(sd_din), 64'd0);
      checkOutput("reset_be", 64'(sd_be), 64'd0);
      reset = 1'b0;

      $display("[TB] single read on port 1");
      push_exp(1, 1'b0, 25'h0000100, 32'hDEADBEEF, 4'h0);
      applyStimulus(1, 1'b0, 25'h0000100, 32'h0, 4'h0, 1);
      wait_drain("read_p1");

      $display("[TB] partial write on port 0, read back on port 2");
      push_exp(0, 1'b1, 25'h1000004, 32'h12345678, 4'b0011);
      applyStimulus(0, 1'b1, 25'h1000004, 32'h12345678, 4'b0011, 1);
      wait_drain("write_p0");
      push_exp(2, 1'b0, 25'h1000004, 32'hAABB5678, 4'h0);
      applyStimulus(2, 1'b0, 25'h1000004, 32'h0, 4'h0, 1);
      wait_drain("readback_p2");

      $display("[TB] all ports requesting continuously");
      reset_dut();
      push_exp(0, 1'b0, 25'h08, 32'h11111111, 4'h0);
      push_exp(1, 1'b0, 25'h0C, 32'h22222222, 4'h0);
      push_exp(2, 1'b0, 25'h10, 32'h33333333, 4'h0);
      push_exp(0, 1'b0, 25'h08, 32'h11111111, 4'h0);
      push_exp(1, 1'b0, 25'h0C, 32'h22222222, 4'h0);
      push_exp(2, 1'b0, 25'h10, 32'h33333333, 4'h0);
      applyStimulus(0, 1'b0, 25'h08, 32'h0, 4'h0, 2);
      applyStimulus(1, 1'b0, 25'h0C, 32'h0, 4'h0, 2);
      applyStimulus(2, 1'b0, 25'h10, 32'h0, 4'h0, 2);
      wait_drain("round_robin");

      $display("[TB] reset during WAIT of a read");
      reset_dut();
      applyStimulus(0, 1'b0, 25'h0000100, 32'h0, 4'h0, 1);
      budget = 50;
      while (!sd_rd && budget > 0) begin @(negedge clk); budget--; end
      while (sd_rd && budget > 0) begin @(negedge clk); budget--; end
      checkOutput("wait_entered", {63'd0, budget == 0}, 64'd0);
      reset = 1'b1;
      cancel_all();
      @(posedge clk);
      #1;
      checkOutput("reset_clears_rd", {63'd0, sd_rd}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push_exp(2, 1'b0, 25'h14, 32'h55555555, 4'h0);
      applyStimulus(2, 1'b0, 25'h14, 32'h0, 4'h0, 1);
      wait_drain("reset_recovery");

      $display("[TB] port 0 holds req across ack with port 1 waiting");
      reset_dut();
      push_exp(0, 1'b0, 25'h08, 32'h11111111, 4'h0);
      push_exp(1, 1'b0, 25'h0C, 32'h22222222, 4'h0);
      push_exp(0, 1'b0, 25'h08, 32'h11111111, 4'h0);
      applyStimulus(0, 1'b0, 25'h08, 32'h0, 4'h0, 2);
      applyStimulus(1, 1'b0, 25'h0C, 32'h0, 4'h0, 1);
      wait_drain("hold_req");

      checkOutput("controller_accesses", 64'(accepts), 64'd14);
      checkOutput("total_acks", 64'(acks_seen), 64'd13);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
